// File: rtl/adp_pkg.sv
// Shared definitions for the address/word datapath:
// output-select encodings, CR width and default data width.
package adp_pkg;
  localparam int ADP_W = 8;
  localparam int CR_W  = 3;

  // SELDATA: 1x = CR, 01 = AC, 00 = WC
  localparam logic [1:0] SEL_WC = 2'b00;
  localparam logic [1:0] SEL_AC = 2'b01;
  localparam logic [1:0] SEL_CR = 2'b10;
endpackage

// File: rtl/addr_word_datapath_if.sv
// Decoder <-> datapath bus: data in, control strobes, and
// CR / DOUT / DVALID / WZ / WTC status back to the decoder.
interface addr_word_datapath_if
  import adp_pkg::*;
#(
  parameter int W = ADP_W
);
  logic [W-1:0]    DIN;
  logic            PLCR;
  logic            PLAR;
  logic            PLWR;
  logic            SELA;
  logic            SELW;
  logic            PLAC;
  logic            ENA;
  logic            INCA;
  logic            DECA;
  logic            PLWC;
  logic            RESW;
  logic            ENW;
  logic            INCW;
  logic            DECW;
  logic [1:0]      SELDATA;
  logic            OEDATA;
  logic [CR_W-1:0] CR;
  logic [W-1:0]    DOUT;
  logic            DVALID;
  logic            WZ;
  logic            WTC;

  modport master (
    output DIN, PLCR, PLAR, PLWR, SELA, SELW,
    output PLAC, ENA, INCA, DECA,
    output PLWC, RESW, ENW, INCW, DECW,
    output SELDATA, OEDATA,
    input  CR, DOUT, DVALID, WZ, WTC
  );

  modport slave (
    input  DIN, PLCR, PLAR, PLWR, SELA, SELW,
    input  PLAC, ENA, INCA, DECA,
    input  PLWC, RESW, ENW, INCW, DECW,
    input  SELDATA, OEDATA,
    output CR, DOUT, DVALID, WZ, WTC
  );
endinterface

// File: rtl/updown_counter.sv
// Loadable up/down counter, priority CLR > LD > EN.
// Ports: CLK, RST, CLR, LD, LDVAL, EN, UP, DN -> Q, WRAP.
module updown_counter #(
  parameter int W = 8
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         CLR,
  input  logic         LD,
  input  logic [W-1:0] LDVAL,
  input  logic         EN,
  input  logic         UP,
  input  logic         DN,
  output logic [W-1:0] Q,
  output logic         WRAP
);
  logic [W-1:0] q_q, q_d;
  logic         wrap_q, wrap_d;

  // UP/DN are only looked at under EN, LDVAL only under LD
  always_comb begin
    q_d    = q_q;
    wrap_d = 1'b0;
    if (CLR) begin
      q_d = '0;
    end else if (LD) begin
      q_d = LDVAL;
    end else if (EN) begin
      if (UP && !DN) begin
        q_d    = q_q + 1'b1;
        wrap_d = &q_q;
      end else if (DN && !UP) begin
        q_d    = q_q - 1'b1;
        wrap_d = ~|q_q;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      q_q    <= '0;
      wrap_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      wrap_q <= wrap_d;
    end
  end

  assign Q    = q_q;
  assign WRAP = wrap_q;
endmodule

// File: rtl/addr_word_datapath.sv
// CR/AR/WR registers, AC/WC counters and registered DOUT.
// Ports: CLK, RST, bus (slave side of addr_word_datapath_if).
module addr_word_datapath
  import adp_pkg::*;
#(
  parameter int W = ADP_W
) (
  input logic                 CLK,
  input logic                 RST,
  addr_word_datapath_if.slave bus
);
  logic [CR_W-1:0] cr_q, cr_d;
  logic [W-1:0]    ar_q, ar_d;
  logic [W-1:0]    wr_q, wr_d;
  logic [W-1:0]    dout_q, dout_d;
  logic            dval_q;
  logic [W-1:0]    ac, wc;
  logic [W-1:0]    ac_ld, wc_ld;
  logic            ac_wrap;
  logic            wc_wrap;

  always_comb begin
    cr_d = cr_q;
    ar_d = ar_q;
    wr_d = wr_q;
    if (bus.PLCR) cr_d = bus.DIN[CR_W-1:0];
    if (bus.PLAR) ar_d = bus.DIN;
    if (bus.PLWR) wr_d = bus.DIN;
  end

  // Register selects use the pre-edge AR/WR value
  assign ac_ld = bus.SELA ? ar_q : bus.DIN;
  assign wc_ld = bus.SELW ? wr_q : bus.DIN;

  always_comb begin
    dout_d = dout_q;
    if (bus.OEDATA) begin
      unique case (1'b1)
        bus.SELDATA[1]:           dout_d = W'(cr_q);
        bus.SELDATA == SEL_AC:    dout_d = ac;
        default:                  dout_d = wc;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cr_q   <= '0;
      ar_q   <= '0;
      wr_q   <= '0;
      dout_q <= '0;
      dval_q <= 1'b0;
    end else begin
      cr_q   <= cr_d;
      ar_q   <= ar_d;
      wr_q   <= wr_d;
      dout_q <= dout_d;
      dval_q <= bus.OEDATA;
    end
  end

  updown_counter #(.W(W)) u_ac (
    .CLK  (CLK),
    .RST  (RST),
    .CLR  (1'b0),
    .LD   (bus.PLAC),
    .LDVAL(ac_ld),
    .EN   (bus.ENA),
    .UP   (bus.INCA),
    .DN   (bus.DECA),
    .Q    (ac),
    .WRAP (ac_wrap)
  );

  updown_counter #(.W(W)) u_wc (
    .CLK  (CLK),
    .RST  (RST),
    .CLR  (bus.RESW),
    .LD   (bus.PLWC),
    .LDVAL(wc_ld),
    .EN   (bus.ENW),
    .UP   (bus.INCW),
    .DN   (bus.DECW),
    .Q    (wc),
    .WRAP (wc_wrap)
  );

  assign bus.CR     = cr_q;
  assign bus.DOUT   = dout_q;
  assign bus.DVALID = dval_q;
  // Zero decode straight off the WC flops
  assign bus.WZ     = ~|wc;
  assign bus.WTC    = wc_wrap;
endmodule

// File: tb/tb_addr_word_datapath.sv
// Directed self-checking bench for addr_word_datapath.
// Inputs change 1ns after the rising edge; checks sit there too.
module tb_addr_word_datapath;
  import adp_pkg::*;

  localparam int W = 8;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  int   total = 0;
  int   bad   = 0;

  addr_word_datapath_if #(.W(W)) bus ();

  addr_word_datapath #(.W(W)) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.DIN     = '0;
    bus.PLCR    = 0; bus.PLAR = 0; bus.PLWR = 0;
    bus.SELA    = 0; bus.SELW = 0;
    bus.PLAC    = 0; bus.ENA  = 0;
    bus.INCA    = 0; bus.DECA = 0;
    bus.PLWC    = 0; bus.RESW = 0; bus.ENW = 0;
    bus.INCW    = 0; bus.DECW = 0;
    bus.SELDATA = 2'b00;
    bus.OEDATA  = 0;
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Capture selected source, then drop strobes
  task automatic show(input logic [1:0] sel);
    idle();
    bus.OEDATA  = 1;
    bus.SELDATA = sel;
    step();
    idle();
  endtask

  initial begin
    idle();
    step();
    step();
    chk("rst_dout", bus.DOUT, 0);
    chk("rst_dvalid", bus.DVALID, 0);
    chk("rst_wz", bus.WZ, 1);
    chk("rst_wtc", bus.WTC, 0);
    chk("rst_cr", bus.CR, 0);
    RST = 0;

    // AR and AC load DIN in the same edge
    bus.DIN = 8'h3C; bus.PLAR = 1; bus.PLAC = 1; bus.SELA = 0;
    step(); idle();
    show(SEL_AC);
    chk("ac_din", bus.DOUT, 8'h3C);
    chk("dvalid_hi", bus.DVALID, 1);
    step();
    chk("dvalid_lo", bus.DVALID, 0);
    chk("dout_hold", bus.DOUT, 8'h3C);
    bus.DIN = 8'h00; bus.PLAC = 1; bus.SELA = 1;
    step(); idle();
    show(SEL_AC);
    chk("ac_from_ar", bus.DOUT, 8'h3C);

    // AC up-wrap, hold, down
    bus.DIN = 8'hFF; bus.PLAC = 1;
    step(); idle();
    bus.ENA = 1; bus.INCA = 1;
    step(); idle();
    show(SEL_AC);
    chk("ac_wrap", bus.DOUT, 8'h00);
    bus.ENA = 1; bus.INCA = 1; bus.DECA = 1;
    step(); idle();
    show(SEL_AC);
    chk("ac_hold", bus.DOUT, 8'h00);
    bus.ENA = 1; bus.DECA = 1;
    step(); idle();
    show(SEL_AC);
    chk("ac_dec", bus.DOUT, 8'hFF);

    // WC down-wrap 0 -> FF
    chk("wz_pre", bus.WZ, 1);
    bus.ENW = 1; bus.DECW = 1;
    step(); idle();
    chk("wtc_dn", bus.WTC, 1);
    chk("wz_dn", bus.WZ, 0);
    step();
    chk("wtc_pulse", bus.WTC, 0);
    show(SEL_WC);
    chk("wc_ff", bus.DOUT, 8'hFF);

    // WC up-wrap FF -> 0
    bus.ENW = 1; bus.INCW = 1;
    step(); idle();
    chk("wtc_up", bus.WTC, 1);
    chk("wz_up", bus.WZ, 1);

    // WC priority
    bus.DIN = 8'h05; bus.PLWC = 1;
    step(); idle();
    chk("wz_ld5", bus.WZ, 0);
    chk("wtc_ld", bus.WTC, 0);
    bus.DIN = 8'h09; bus.RESW = 1; bus.PLWC = 1;
    bus.ENW = 1; bus.INCW = 1;
    step(); idle();
    chk("wz_resw", bus.WZ, 1);
    chk("wtc_resw", bus.WTC, 0);
    bus.DIN = 8'h07; bus.PLWC = 1; bus.ENW = 1; bus.INCW = 1;
    step(); idle();
    show(SEL_WC);
    chk("wc_ld_over_en", bus.DOUT, 8'h07);

    // WR and WC from DIN together, then WC from WR
    bus.DIN = 8'h22; bus.PLWR = 1; bus.PLWC = 1; bus.SELW = 0;
    step(); idle();
    bus.DIN = 8'h00; bus.PLWC = 1; bus.SELW = 1;
    step(); idle();
    show(SEL_WC);
    chk("wc_from_wr", bus.DOUT, 8'h22);

    // Output mux
    bus.DIN = 8'hFD; bus.PLCR = 1;
    step(); idle();
    chk("cr", bus.CR, 3'b101);
    bus.DIN = 8'h12; bus.PLAC = 1;
    step(); idle();
    bus.DIN = 8'h34; bus.PLWC = 1;
    step(); idle();
    show(2'b10);
    chk("mux_cr10", bus.DOUT, 8'h05);
    show(2'b11);
    chk("mux_cr11", bus.DOUT, 8'h05);
    show(SEL_AC);
    chk("mux_ac", bus.DOUT, 8'h12);
    show(SEL_WC);
    chk("mux_wc", bus.DOUT, 8'h34);

    // Capture and count together: old AC goes out
    bus.OEDATA = 1; bus.SELDATA = SEL_AC;
    bus.ENA = 1; bus.INCA = 1;
    step(); idle();
    chk("simul_old", bus.DOUT, 8'h12);
    show(SEL_AC);
    chk("simul_new", bus.DOUT, 8'h13);

    // X on unsampled qualifiers
    for (int i = 0; i < 50; i++) begin
      bus.DIN     = 8'($urandom);
      bus.INCA    = 'x; bus.DECA = 'x; bus.SELA = 'x;
      bus.INCW    = 'x; bus.DECW = 'x; bus.SELW = 'x;
      bus.SELDATA = 'x;
      step();
      chk("xsafe", 32'($isunknown({bus.CR, bus.DOUT, bus.DVALID,
                                    bus.WZ, bus.WTC})), 0);
    end
    idle();
    show(SEL_AC);
    chk("xsafe_ac", bus.DOUT, 8'h13);
    show(SEL_WC);
    chk("xsafe_wc", bus.DOUT, 8'h34);

    // Async reset in the middle of counting/capturing
    bus.DIN = 8'hFF; bus.PLWC = 1;
    step(); idle();
    bus.ENW = 1; bus.INCW = 1; bus.ENA = 1; bus.INCA = 1;
    bus.OEDATA = 1; bus.SELDATA = SEL_AC;
    step();
    chk("pre_rst_wtc", bus.WTC, 1);
    chk("pre_rst_dv", bus.DVALID, 1);
    #2;
    RST = 1;
    #1;
    chk("arst_dout", bus.DOUT, 0);
    chk("arst_dv", bus.DVALID, 0);
    chk("arst_wtc", bus.WTC, 0);
    chk("arst_wz", bus.WZ, 1);
    chk("arst_cr", bus.CR, 0);
    idle();
    step();
    RST = 0;
    bus.DIN = 8'h03; bus.PLCR = 1;
    step(); idle();
    chk("post_rst_cr", bus.CR, 3'b011);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/addr_word_datapath.md
# addr_word_datapath

Register and counter datapath driven by the instruction decoder's control strobes. It holds:
- the 3-bit control register (CR), which feeds CR back to the decoder;
- the address register (AR), the word register (WR), the address counter (AC) and the word counter (WC);
- the registered data-out port.

Each clock edge applies the strobe set the decoder produced for the current instruction. The block reports word-counter terminal status to the sequencer.

## Interface
Parameters:
- `W`, default 8: width of DIN, AR, WR, AC, WC and DOUT.

Ports:
- `CLK` in 1: single clock; all state updates on rising edge.
- `RST` in 1: asynchronous, active-high reset.
- `DIN` in W: parallel data bus. CR loads from DIN[2:0].
- `PLCR`, `PLAR`, `PLWR` in 1 each: load CR, AR or WR from DIN.
- `SELA` in 1: AC load source. 1 = AR, 0 = DIN.
- `SELW` in 1: WC load source. 1 = WR, 0 = DIN.
- `PLAC`, `ENA`, `INCA`, `DECA` in 1 each: AC load, enable, up, down.
- `PLWC`, `RESW`, `ENW`, `INCW`, `DECW` in 1 each: WC load, synchronous clear, enable, up, down.
- `SELDATA` in 2: output source select. 1x = CR zero-extended, 01 = AC, 00 = WC.
- `OEDATA` in 1: output capture strobe.
- `CR` out 3: control register, fed back to the decoder.
- `DOUT` out W: registered output data.
- `DVALID` out 1: DOUT updated this cycle.
- `WZ` out 1: WC == 0, registered.
- `WTC` out 1: one-cycle pulse on WC wrap, either up-count all-ones→0 or down-count 0→all-ones.

## Operation
- **Reset.** CR, AR, WR, AC, WC and DOUT = 0. DVALID = 0, WTC = 0, WZ = 1.
- **X-safety.** Qualifier inputs are don't-care, and may be X, whenever their strobe is inactive:
  - SELA and SELW are sampled only when PLAC / PLWC = 1.
  - INCA/DECA are sampled only when ENA = 1. INCW/DECW are sampled only when ENW = 1.
  - SELDATA is sampled only when OEDATA = 1.
  - X on an unsampled qualifier must never reach state.
- **CR.** PLCR=1: CR ← DIN[2:0].
- **AR / WR.** PLAR=1: AR ← DIN. PLWR=1: WR ← DIN.
- **Register-to-counter load.** A register load and a counter load asserted together both take DIN in the same edge; the counter does not see the old register value.
  - PLAR=1 with PLAC=1 and SELA=0 loads AR and AC from DIN in the same edge.
  - The same rule applies to WR/WC.
- **AC priority:** PLAC > ENA.
  - PLAC=1: AC ← (SELA ? AR : DIN).
  - ENA=1 with INCA=1, DECA=0: AC+1 mod 2^W.
  - ENA=1 with DECA=1, INCA=0: AC−1 mod 2^W.
  - ENA=1 with INCA == DECA: hold.
- **WC priority:** RESW > PLWC > ENW.
  - RESW=1: WC ← 0.
  - PLWC=1: WC ← (SELW ? WR : DIN).
  - ENW=1: up/down/hold, same rules as AC.
- **WTC.** Asserted the cycle after an ENW count that wraps. It is not asserted on a load or a clear.
- **WZ.** Reflects WC after every update, including loads and RESW.
- **Output capture.** OEDATA=1: DOUT ← selected source, pre-edge value, and DVALID=1 next cycle.
  - OEDATA=0: DOUT holds and DVALID=0.
- **Simultaneous events.** All loads and counts in one edge use pre-edge values.
  - Example: OEDATA with ENA in the same cycle outputs the old AC.

## Timing
- All outputs are registered. Latency from strobe to visible state is 1 cycle.
- CR feedback is valid one cycle after PLCR, so the decoder sees the new CR on the next instruction.
- Sustains one instruction per cycle with no stalls and no handshake back-pressure.
- **RST mid-operation.** Asserting RST in the middle of a count or capture clears everything immediately, without waiting for CLK. DVALID and WTC are forced low.
- **First edge after RST release.** The first rising edge after RST deasserts is a normal operating edge.

## Structure
- **Shared package** `adp_pkg`:
  - SELDATA encodings: `SEL_WC`=2'b00, `SEL_AC`=2'b01, `SEL_CR`=2'b1x.
  - `CR_W`=3.
  - Default `W`.
- **Sub-module** `updown_counter` (params: W).
  - Ports: CLK, RST, CLR, LD, LDVAL, EN, UP, DN, Q, WRAP.
  - Instantiated twice: AC has CLR tied 0; WC uses the WRAP output.

## Test plan
- **Reset:** assert RST mid-count → every output is 0 immediately, except WZ=1.
- **Load path:** DIN=0x3C with PLAR=PLAC=1, SELA=0 → AR=AC=0x3C next cycle.
  - Then PLAC=1, SELA=1 with DIN=0x00 → AC=0x3C.
- **Wrap:** AC=0xFF, ENA=INCA=1 → AC=0x00.
  - WC=0x00, ENW=DECW=1 → WC=0xFF with WTC pulsing for one cycle, WZ 1→0.
  - INCA=DECA=1 → hold.
- **WC priority:** RESW=1, PLWC=1, ENW=1 with WC=0x05 → WC=0, WZ=1.
  - PLWC=1, ENW=1, SELW=0, DIN=0x07 → WC=0x07.
- **Output mux:** CR=3'b101, AC=0x12, WC=0x34.
  - SELDATA=1x → DOUT=0x05. SELDATA=01 → DOUT=0x12. SELDATA=00 → DOUT=0x34.
  - DVALID is high for exactly the cycles following OEDATA.
- **X-safety:** drive INCA/DECA/SELA/SELDATA = X while their strobes are 0 for 50 random cycles → no X appears on any output.
